mem_access: RTL and testbench
=============================

MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 clk  in  1  sole clock; all state SHALL update on rising edge.
REQ-002 rst  in  1  synchronous, active-high reset (`Enable); SHALL be sampled only on clk rising edge.
REQ-003 stall  in  6  pipeline stall vector; bit 4 = MEM stage held.
REQ-004 mem_rw  in  `RegAddrBus; mem_wreg  in  1; mem_wdata  in  `RegBus: destination, write-enable and ALU result from the ex_mem register.
REQ-005 mem_whilo  in  1; mem_hi, mem_lo  in  `RegBus: HI/LO write request.
REQ-006 mem_aluop  in  `AluOpBus; mem_addr  in  `RegBus; mem_reg2  in  `RegBus: op code, effective address, store source.
REQ-007 wb_rw, wb_wreg, wb_wdata, wb_whilo, wb_hi, wb_lo  out  (widths as inputs): results to mem_wb.
REQ-008 stallreq  out  1  MEM-stage stall request to the stall controller.
REQ-009 dbus_req  out  1; dbus_we  out  1; dbus_addr  out  32; dbus_sel  out  4; dbus_wdata  out  32: data-bus master, all registered.
REQ-010 dbus_rdata  in  32; dbus_ack  in  1: data-bus response; ack valid only while dbus_req=1.
REQ-011 misalign  out  1  high while the current memory op is misaligned.

Function
REQ-012 Memory ops SHALL be EXE_LB/LBU/LH/LHU/LW_OP (loads) and EXE_SB/SH/SW_OP (stores); all other aluops are pass-through.
REQ-013 Pass-through: wb_* SHALL equal the corresponding mem_* inputs combinationally, stallreq=0, no bus activity.
REQ-014 FSM states IDLE, REQ, DONE; reset state IDLE.
REQ-015 IDLE with an aligned memory op: stallreq=1 combinationally; next edge -> REQ with dbus_req=1 and bus fields loaded.
REQ-016 dbus_addr = {mem_addr[31:2],2'b00}; dbus_we=1 for stores, 0 for loads.
REQ-017 Big-endian lanes: byte, addr[1:0]=00/01/10/11 -> sel 1000/0100/0010/0001; half, addr[1]=0/1 -> sel 1100/0011; word -> sel 1111; loads use the same sel.
REQ-018 Store data: SB replicates mem_reg2[7:0] into all four bytes; SH replicates mem_reg2[15:0] into both halves; SW passes mem_reg2 unchanged.
REQ-019 REQ: stallreq=1; bus outputs held stable until dbus_ack=1; on the ack edge, dbus_rdata SHALL be captured, dbus_req cleared, and the FSM SHALL enter DONE.
REQ-020 DONE: stallreq=0; for loads, wb_wdata = the selected lane of the captured data, sign-extended (LB/LH) or zero-extended (LBU/LHU), or the full word (LW); for stores, wb_wdata=mem_wdata.
REQ-021 DONE -> IDLE on an edge with stall[4]=0; DONE SHALL be held while stall[4]=1 (a downstream stall), with no re-issue.
REQ-022 Misaligned (half with addr[0]=1; word with addr[1:0]!=00): no bus access, misalign=1, stallreq=0, wb_wreg=0, FSM stays IDLE.
REQ-023 Minimum load/store latency: 2 stall cycles (zero-wait ack in the first REQ cycle); each additional wait cycle adds one.
REQ-024 wb_rw, wb_wreg, wb_whilo, wb_hi and wb_lo SHALL pass through in all states, except as overridden by REQ-022.

Reset
REQ-025 rst=1 at an edge: FSM -> IDLE; dbus_req, dbus_we, dbus_addr, dbus_sel, dbus_wdata and the capture register -> 0.
REQ-026 While rst=1: all wb_* outputs = 0 (wb_rw=`NOPRegAddr), stallreq=0, misalign=0.
REQ-027 Reset in REQ SHALL abandon the access; a late dbus_ack SHALL be ignored.

Verification
REQ-028 LW, addr 0x100, ack in the first REQ cycle, rdata 0x12345678 -> stallreq high 2 cycles; wb_wdata=0x12345678 in DONE.
REQ-029 LB, addr 0x103, rdata 0x000000F0 -> sel 0001; wb_wdata=0xFFFFFFF0. LBU, same stimulus -> wb_wdata=0x000000F0.
REQ-030 SH, addr 0x202, reg2 0xAAAA1234, ack after 3 wait cycles -> dbus_we=1, sel 0011, wdata 0x12341234, addr 0x200; stallreq high 5 cycles.
REQ-031 LW, addr 0x101 -> misalign=1, dbus_req never asserted, wb_wreg=0, stallreq=0.
REQ-032 LW acked while stall[4]=1 for 2 extra cycles -> FSM stays in DONE, wb_wdata stable, single bus transaction.
REQ-033 rst during REQ, then ack one cycle later -> dbus_req=0 after the reset edge; ack ignored; FSM IDLE.

Source files
------------

// File: rtl/mem_access.sv
// rtl/mem_access.sv - MEM stage load/store unit driving a registered big-endian data bus
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   stall[5:0]                pipeline stall vector, bit 4 holds the MEM stage
//   mem_rw, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo,
//   mem_aluop, mem_addr, mem_reg2   ex_mem register contents
//   wb_rw, wb_wreg, wb_wdata, wb_whilo, wb_hi, wb_lo   results to mem_wb
//   stallreq                  MEM-stage stall request
//   dbus_req, dbus_we, dbus_addr, dbus_sel, dbus_wdata   registered bus master outputs
//   dbus_rdata, dbus_ack      bus response
//   misalign                  current memory op is misaligned

module mem_access (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic [4:0]  mem_rw,
    input  logic        mem_wreg,
    input  logic [31:0] mem_wdata,
    input  logic        mem_whilo,
    input  logic [31:0] mem_hi,
    input  logic [31:0] mem_lo,
    input  logic [7:0]  mem_aluop,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_reg2,
    output logic [4:0]  wb_rw,
    output logic        wb_wreg,
    output logic [31:0] wb_wdata,
    output logic        wb_whilo,
    output logic [31:0] wb_hi,
    output logic [31:0] wb_lo,
    output logic        stallreq,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [3:0]  dbus_sel,
    output logic [31:0] dbus_wdata,
    input  logic [31:0] dbus_rdata,
    input  logic        dbus_ack,
    output logic        misalign
);

    localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

    localparam logic [4:0] NOP_REG_ADDR = 5'b00000;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_n;

    logic        is_load;
    logic        is_store;
    logic        is_signed;
    logic [1:0]  size;
    logic        is_mem;
    logic        misaligned;
    logic        start;

    logic [3:0]  sel_c;
    logic [31:0] wdata_c;

    logic [31:0] rdata_q;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] load_data;

    // Opcode decode
    always_comb begin
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_signed = 1'b0;
        size      = SZ_WORD;
        case (mem_aluop)
            EXE_LB_OP:  begin is_load  = 1'b1; is_signed = 1'b1; size = SZ_BYTE; end
            EXE_LBU_OP: begin is_load  = 1'b1;                   size = SZ_BYTE; end
            EXE_LH_OP:  begin is_load  = 1'b1; is_signed = 1'b1; size = SZ_HALF; end
            EXE_LHU_OP: begin is_load  = 1'b1;                   size = SZ_HALF; end
            EXE_LW_OP:  begin is_load  = 1'b1;                   size = SZ_WORD; end
            EXE_SB_OP:  begin is_store = 1'b1;                   size = SZ_BYTE; end
            EXE_SH_OP:  begin is_store = 1'b1;                   size = SZ_HALF; end
            EXE_SW_OP:  begin is_store = 1'b1;                   size = SZ_WORD; end
            default:    begin is_load  = 1'b0; is_store = 1'b0; end
        endcase
    end

    assign is_mem     = is_load | is_store;
    assign misaligned = is_mem &&
                        (((size == SZ_HALF) && mem_addr[0]) ||
                         ((size == SZ_WORD) && (mem_addr[1:0] != 2'b00)));
    assign start      = is_mem && !misaligned;

    // Big-endian lane enables and store data replication for the next request
    always_comb begin
        sel_c   = 4'b1111;
        wdata_c = mem_reg2;
        case (size)
            SZ_BYTE: begin
                sel_c   = 4'b1000 >> mem_addr[1:0];
                wdata_c = {4{mem_reg2[7:0]}};
            end
            SZ_HALF: begin
                sel_c   = mem_addr[1] ? 4'b0011 : 4'b1100;
                wdata_c = {2{mem_reg2[15:0]}};
            end
            default: begin
                sel_c   = 4'b1111;
                wdata_c = mem_reg2;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: if (start)     state_n = S_REQ;
            S_REQ:  if (dbus_ack)  state_n = S_DONE;
            // The op stays parked here while a downstream stall holds MEM,
            // so the access is never issued twice.
            S_DONE: if (!stall[4]) state_n = S_IDLE;
            default:               state_n = S_IDLE;
        endcase
    end

    // Bus master registers and read-data capture
    always_ff @(posedge clk) begin
        if (rst) begin
            dbus_req   <= 1'b0;
            dbus_we    <= 1'b0;
            dbus_addr  <= 32'h0;
            dbus_sel   <= 4'h0;
            dbus_wdata <= 32'h0;
            rdata_q    <= 32'h0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        dbus_req   <= 1'b1;
                        dbus_we    <= is_store;
                        dbus_addr  <= {mem_addr[31:2], 2'b00};
                        dbus_sel   <= sel_c;
                        dbus_wdata <= wdata_c;
                    end
                end
                S_REQ: begin
                    if (dbus_ack) begin
                        dbus_req <= 1'b0;
                        rdata_q  <= dbus_rdata;
                    end
                end
                default: begin
                    dbus_req <= 1'b0;
                end
            endcase
        end
    end

    // Lane extraction from the captured word; the ex_mem inputs are still
    // held while in DONE, so the live address and opcode pick the lane.
    always_comb begin
        case (mem_addr[1:0])
            2'b00:   byte_lane = rdata_q[31:24];
            2'b01:   byte_lane = rdata_q[23:16];
            2'b10:   byte_lane = rdata_q[15:8];
            default: byte_lane = rdata_q[7:0];
        endcase
        half_lane = mem_addr[1] ? rdata_q[15:0] : rdata_q[31:16];
        case (size)
            SZ_BYTE: load_data = is_signed ? {{24{byte_lane[7]}}, byte_lane}
                                           : {24'h0, byte_lane};
            SZ_HALF: load_data = is_signed ? {{16{half_lane[15]}}, half_lane}
                                           : {16'h0, half_lane};
            default: load_data = rdata_q;
        endcase
    end

    // Write-back outputs, stall request and misalignment flag
    always_comb begin
        wb_rw    = mem_rw;
        wb_wreg  = mem_wreg;
        wb_wdata = mem_wdata;
        wb_whilo = mem_whilo;
        wb_hi    = mem_hi;
        wb_lo    = mem_lo;
        stallreq = 1'b0;
        misalign = 1'b0;

        if (rst) begin
            wb_rw    = NOP_REG_ADDR;
            wb_wreg  = 1'b0;
            wb_wdata = 32'h0;
            wb_whilo = 1'b0;
            wb_hi    = 32'h0;
            wb_lo    = 32'h0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (misaligned) begin
                        misalign = 1'b1;
                        wb_wreg  = 1'b0;
                    end else if (start) begin
                        stallreq = 1'b1;
                    end
                end
                S_REQ: begin
                    stallreq = 1'b1;
                end
                S_DONE: begin
                    if (is_load) begin
                        wb_wdata = load_data;
                    end
                end
                default: begin
                    stallreq = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - directed self-checking bench for mem_access

module tb_mem_access;

    localparam logic [7:0] NOP_OP = 8'h00;
    localparam logic [7:0] LB_OP  = 8'b1110_0000;
    localparam logic [7:0] LH_OP  = 8'b1110_0001;
    localparam logic [7:0] LW_OP  = 8'b1110_0011;
    localparam logic [7:0] LBU_OP = 8'b1110_0100;
    localparam logic [7:0] LHU_OP = 8'b1110_0101;
    localparam logic [7:0] SB_OP  = 8'b1110_1000;
    localparam logic [7:0] SH_OP  = 8'b1110_1001;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic [4:0]  mem_rw;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic        mem_whilo;
    logic [31:0] mem_hi;
    logic [31:0] mem_lo;
    logic [7:0]  mem_aluop;
    logic [31:0] mem_addr;
    logic [31:0] mem_reg2;
    logic [4:0]  wb_rw;
    logic        wb_wreg;
    logic [31:0] wb_wdata;
    logic        wb_whilo;
    logic [31:0] wb_hi;
    logic [31:0] wb_lo;
    logic        stallreq;
    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [3:0]  dbus_sel;
    logic [31:0] dbus_wdata;
    logic [31:0] dbus_rdata;
    logic        dbus_ack;
    logic        misalign;

    int checks = 0;
    int errors = 0;
    int txn_count = 0;
    logic req_prev = 1'b0;

    logic [31:0] a_addr;
    logic [3:0]  a_sel;
    logic        a_we;
    logic [31:0] a_wdata;
    logic        bus_unstable;
    int          stall_cnt;
    int          txn_base;
    logic [31:0] held;

    mem_access dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .mem_rw     (mem_rw),
        .mem_wreg   (mem_wreg),
        .mem_wdata  (mem_wdata),
        .mem_whilo  (mem_whilo),
        .mem_hi     (mem_hi),
        .mem_lo     (mem_lo),
        .mem_aluop  (mem_aluop),
        .mem_addr   (mem_addr),
        .mem_reg2   (mem_reg2),
        .wb_rw      (wb_rw),
        .wb_wreg    (wb_wreg),
        .wb_wdata   (wb_wdata),
        .wb_whilo   (wb_whilo),
        .wb_hi      (wb_hi),
        .wb_lo      (wb_lo),
        .stallreq   (stallreq),
        .dbus_req   (dbus_req),
        .dbus_we    (dbus_we),
        .dbus_addr  (dbus_addr),
        .dbus_sel   (dbus_sel),
        .dbus_wdata (dbus_wdata),
        .dbus_rdata (dbus_rdata),
        .dbus_ack   (dbus_ack),
        .misalign   (misalign)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (dbus_req && !req_prev) txn_count++;
        req_prev = dbus_req;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [7:0] op, input logic [31:0] addr,
                          input logic [31:0] reg2, input logic [31:0] wdata);
        mem_aluop = op;
        mem_addr  = addr;
        mem_reg2  = reg2;
        mem_wdata = wdata;
    endtask

    // Runs one access to completion: counts stallreq cycles, records the
    // first bus request and flags any change while waiting, and acks after
    // the given number of wait cycles. Bounded so a stuck DUT still ends.
    task automatic access(input int waits, input logic [31:0] rdata, output int cnt);
        int  w;
        bit  seen;
        w = 0;
        seen = 1'b0;
        cnt = 0;
        bus_unstable = 1'b0;
        #1;
        for (int c = 0; c < 32; c++) begin
            if (!stallreq) break;
            cnt++;
            if (dbus_req) begin
                if (!seen) begin
                    seen    = 1'b1;
                    a_addr  = dbus_addr;
                    a_sel   = dbus_sel;
                    a_we    = dbus_we;
                    a_wdata = dbus_wdata;
                end else if (dbus_addr !== a_addr || dbus_sel !== a_sel ||
                             dbus_we !== a_we || dbus_wdata !== a_wdata) begin
                    bus_unstable = 1'b1;
                end
                if (w == waits) begin
                    dbus_ack   = 1'b1;
                    dbus_rdata = rdata;
                end else begin
                    w++;
                end
            end
            tick();
            dbus_ack = 1'b0;
        end
    endtask

    initial begin
        rst        = 1'b1;
        stall      = 6'b0;
        dbus_ack   = 1'b0;
        dbus_rdata = 32'h0;
        mem_rw     = 5'd3;
        mem_wreg   = 1'b1;
        mem_whilo  = 1'b1;
        mem_hi     = 32'h1111_2222;
        mem_lo     = 32'h3333_4444;
        set_op(LW_OP, 32'h0000_0101, 32'h0, 32'hDEAD_BEEF);
        a_addr = 32'h0; a_sel = 4'h0; a_we = 1'b0; a_wdata = 32'h0;
        bus_unstable = 1'b0;

        // Reset: outputs forced to zero while rst is high
        tick();
        tick();
        check("rst_wb_rw", {27'h0, wb_rw}, 32'h0);
        check("rst_wb_wreg", {31'h0, wb_wreg}, 32'h0);
        check("rst_wb_wdata", wb_wdata, 32'h0);
        check("rst_wb_hilo", {31'h0, wb_whilo} | wb_hi | wb_lo, 32'h0);
        check("rst_stallreq", {31'h0, stallreq}, 32'h0);
        check("rst_misalign", {31'h0, misalign}, 32'h0);
        check("rst_dbus_req", {31'h0, dbus_req}, 32'h0);
        check("rst_dbus_sel", {28'h0, dbus_sel}, 32'h0);

        // Pass-through op
        rst = 1'b0;
        set_op(NOP_OP, 32'h0000_0100, 32'h0, 32'hCAFE_F00D);
        mem_rw = 5'd7;
        #1;
        check("pt_wb_wdata", wb_wdata, 32'hCAFE_F00D);
        check("pt_wb_rw", {27'h0, wb_rw}, 32'd7);
        check("pt_wb_hi", wb_hi, 32'h1111_2222);
        check("pt_wb_lo", wb_lo, 32'h3333_4444);
        check("pt_stallreq", {31'h0, stallreq}, 32'h0);
        tick();
        check("pt_dbus_req", {31'h0, dbus_req}, 32'h0);

        // LW 0x100, zero-wait ack
        set_op(LW_OP, 32'h0000_0100, 32'h0, 32'h0000_0055);
        access(0, 32'h1234_5678, stall_cnt);
        check("lw_stall_cycles", stall_cnt, 32'd2);
        check("lw_addr", a_addr, 32'h0000_0100);
        check("lw_sel", {28'h0, a_sel}, 32'hF);
        check("lw_we", {31'h0, a_we}, 32'h0);
        check("lw_wb_wdata", wb_wdata, 32'h1234_5678);
        check("lw_wb_wreg", {31'h0, wb_wreg}, 32'h1);
        check("lw_done_req", {31'h0, dbus_req}, 32'h0);
        tick();

        // LB 0x103 sign-extended, then LBU same stimulus
        set_op(LB_OP, 32'h0000_0103, 32'h0, 32'h0);
        access(0, 32'h0000_00F0, stall_cnt);
        check("lb_sel", {28'h0, a_sel}, 32'h1);
        check("lb_addr", a_addr, 32'h0000_0100);
        check("lb_wb_wdata", wb_wdata, 32'hFFFF_FFF0);
        tick();
        set_op(LBU_OP, 32'h0000_0103, 32'h0, 32'h0);
        access(0, 32'h0000_00F0, stall_cnt);
        check("lbu_sel", {28'h0, a_sel}, 32'h1);
        check("lbu_wb_wdata", wb_wdata, 32'h0000_00F0);
        tick();

        // LH upper half, LHU lower half
        set_op(LH_OP, 32'h0000_0100, 32'h0, 32'h0);
        access(1, 32'h8001_7FFF, stall_cnt);
        check("lh_stall_cycles", stall_cnt, 32'd3);
        check("lh_sel", {28'h0, a_sel}, 32'hC);
        check("lh_wb_wdata", wb_wdata, 32'hFFFF_8001);
        tick();
        set_op(LHU_OP, 32'h0000_0102, 32'h0, 32'h0);
        access(0, 32'h8001_F00F, stall_cnt);
        check("lhu_sel", {28'h0, a_sel}, 32'h3);
        check("lhu_wb_wdata", wb_wdata, 32'h0000_F00F);
        tick();

        // SH 0x202, three wait cycles
        set_op(SH_OP, 32'h0000_0202, 32'hAAAA_1234, 32'h0000_0077);
        access(3, 32'hFFFF_FFFF, stall_cnt);
        check("sh_stall_cycles", stall_cnt, 32'd5);
        check("sh_we", {31'h0, a_we}, 32'h1);
        check("sh_sel", {28'h0, a_sel}, 32'h3);
        check("sh_wdata", a_wdata, 32'h1234_1234);
        check("sh_addr", a_addr, 32'h0000_0200);
        check("sh_bus_stable", {31'h0, bus_unstable}, 32'h0);
        check("sh_wb_wdata", wb_wdata, 32'h0000_0077);
        tick();

        // SB 0x101 replicates the byte
        set_op(SB_OP, 32'h0000_0101, 32'h1234_56AB, 32'h0);
        access(0, 32'h0, stall_cnt);
        check("sb_sel", {28'h0, a_sel}, 32'h4);
        check("sb_wdata", a_wdata, 32'hABAB_ABAB);
        tick();

        // Misaligned LW 0x101: no bus access
        txn_base = txn_count;
        set_op(LW_OP, 32'h0000_0101, 32'h0, 32'h0000_0099);
        #1;
        check("mis_misalign", {31'h0, misalign}, 32'h1);
        check("mis_stallreq", {31'h0, stallreq}, 32'h0);
        check("mis_wb_wreg", {31'h0, wb_wreg}, 32'h0);
        tick();
        tick();
        check("mis_dbus_req", {31'h0, dbus_req}, 32'h0);
        check("mis_txn", txn_count - txn_base, 32'd0);
        set_op(LH_OP, 32'h0000_0203, 32'h0, 32'h0);
        #1;
        check("mis_lh_misalign", {31'h0, misalign}, 32'h1);

        // LW completes while a downstream stall holds MEM for 2 cycles
        tick();
        txn_base = txn_count;
        set_op(LW_OP, 32'h0000_0104, 32'h0, 32'h0);
        access(0, 32'hA5A5_0F0F, stall_cnt);
        stall = 6'b01_0000;
        held  = wb_wdata;
        check("hold_wb_wdata0", held, 32'hA5A5_0F0F);
        tick();
        tick();
        check("hold_wb_wdata2", wb_wdata, 32'hA5A5_0F0F);
        check("hold_stallreq", {31'h0, stallreq}, 32'h0);
        check("hold_dbus_req", {31'h0, dbus_req}, 32'h0);
        stall = 6'b0;
        tick();
        check("hold_txn", txn_count - txn_base, 32'd1);
        set_op(NOP_OP, 32'h0, 32'h0, 32'h0000_0042);

        // Reset while in REQ, late ack ignored
        tick();
        txn_base = txn_count;
        set_op(LW_OP, 32'h0000_0300, 32'h0, 32'h0);
        tick();
        check("rreq_dbus_req", {31'h0, dbus_req}, 32'h1);
        rst = 1'b1;
        tick();
        check("rreq_req_after_rst", {31'h0, dbus_req}, 32'h0);
        rst = 1'b0;
        set_op(NOP_OP, 32'h0, 32'h0, 32'h0000_0042);
        dbus_ack   = 1'b1;
        dbus_rdata = 32'hBAD0_BAD0;
        tick();
        dbus_ack = 1'b0;
        check("rreq_ack_ignored", wb_wdata, 32'h0000_0042);
        check("rreq_stallreq", {31'h0, stallreq}, 32'h0);
        check("rreq_dbus_req2", {31'h0, dbus_req}, 32'h0);
        // FSM must be in IDLE: a new load asserts stallreq and then issues
        set_op(LW_OP, 32'h0000_0300, 32'h0, 32'h0);
        access(0, 32'h0BAD_F00D, stall_cnt);
        check("rreq_idle_restart", stall_cnt, 32'd2);
        check("rreq_new_data", wb_wdata, 32'h0BAD_F00D);
        check("rreq_txn", txn_count - txn_base, 32'd2);
        tick();
        set_op(NOP_OP, 32'h0, 32'h0, 32'h0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
